module_input_gray_codec: RTL and testbench

Parametrised successor to the 4-bit switch-input Gray decoder. It takes a WIDTH-bit code from board switches and passes it through a 2-FF synchroniser, a refresh-tick sampler and a consecutive-sample stability filter. It then converts the filtered code Gray->binary or binary->Gray, selected at run time by mode_i. It also flags illegal Gray steps and emits a one-cycle valid pulse on every output update. It sits between the FPGA input pins and the display/LED logic.

---
 rtl/gray_pkg.sv | 12 +
 rtl/module_gray_conv.sv | 27 ++
 rtl/module_input_gray_codec.sv | 128 ++++++++++++
 tb/tb_module_input_gray_codec.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants for the switch-input Gray codec: conversion mode encoding
// and default timing parameters sized for a 27 MHz board clock.
package gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // ~100 ms between samples at 27 MHz, slow enough to ride over switch bounce
    localparam int DEFAULT_INPUT_REFRESH  = 2700000;
    localparam int DEFAULT_STABLE_SAMPLES = 3;

endpackage

// File: rtl/module_gray_conv.sv
// Combinational WIDTH-bit code converter: Gray->binary when mode_i is
// MODE_G2B, binary->Gray when mode_i is MODE_B2G.
module module_gray_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] code_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] code_o
);

    logic [WIDTH-1:0] bin_code;
    logic [WIDTH-1:0] gray_code;

    // Each binary bit is the XOR of all Gray bits at and above its position.
    always_comb begin
        bin_code = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_code[i] = ^(code_i >> i);
        end
    end

    assign gray_code = code_i ^ (code_i >> 1);
    assign code_o    = (mode_i == MODE_B2G) ? gray_code : bin_code;

endmodule

// File: rtl/module_input_gray_codec.sv
// Switch-input code path: 2-FF synchroniser, slow refresh sampler, stability
// filter, then run-time selectable Gray/binary conversion with step checking.
module module_input_gray_codec
    import gray_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int INPUT_REFRESH  = DEFAULT_INPUT_REFRESH,
    parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] codigo_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] codigo_o,
    output logic             valid_o,
    output logic             step_err_o
);

    localparam int RW = $clog2(INPUT_REFRESH);
    localparam int SW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [RW-1:0] REFRESH_LAST  = RW'(INPUT_REFRESH - 1);
    localparam logic [SW-1:0] STABLE_TARGET = SW'(STABLE_SAMPLES);

    logic [RW-1:0]    refresh_cnt;
    logic             tick;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] committed;
    logic [SW-1:0]    stable_cnt;
    logic [SW-1:0]    stable_next;
    logic             mode_r;
    logic             commit;
    logic             mode_chg;
    logic             update;
    logic             single_step;
    logic [WIDTH-1:0] step_diff;
    logic [WIDTH-1:0] conv_src;
    logic [WIDTH-1:0] conv_code;

    assign tick = (refresh_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            refresh_cnt <= REFRESH_LAST;
        end else if (tick) begin
            refresh_cnt <= REFRESH_LAST;
        end else begin
            refresh_cnt <= refresh_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= codigo_i;
            sync2 <= sync1;
        end
    end

    // Run length of equal samples, saturating at the commit threshold.
    always_comb begin
        stable_next = stable_cnt;
        if (sync2 != candidate) begin
            stable_next = SW'(1);
        end else if (stable_cnt < STABLE_TARGET) begin
            stable_next = stable_cnt + 1'b1;
        end
    end

    assign commit = tick && (stable_next >= STABLE_TARGET) && (sync2 != committed);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            candidate  <= '0;
            stable_cnt <= '0;
            committed  <= '0;
        end else begin
            if (tick) begin
                candidate  <= sync2;
                stable_cnt <= stable_next;
            end
            if (commit) begin
                committed <= sync2;
            end
        end
    end

    // A legal Gray step flips exactly one bit: diff is non-zero and a power of two.
    assign step_diff   = sync2 ^ committed;
    assign single_step = (step_diff != '0) && ((step_diff & (step_diff - 1'b1)) == '0);

    assign mode_chg = (mode_i != mode_r);
    assign update   = commit || mode_chg;
    assign conv_src = commit ? sync2 : committed;

    module_gray_conv #(
        .WIDTH (WIDTH)
    ) u_conv (
        .code_i (conv_src),
        .mode_i (mode_i),
        .code_o (conv_code)
    );

    // valid_o is a one-cycle pulse with no ready: the consumer takes codigo_o
    // in the pulse cycle; codigo_o and step_err_o then hold until the next update.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode_r     <= MODE_G2B;
            codigo_o   <= '0;
            valid_o    <= 1'b0;
            step_err_o <= 1'b0;
        end else begin
            mode_r  <= mode_i;
            valid_o <= update;
            if (commit) begin
                codigo_o   <= conv_code;
                step_err_o <= (mode_i == MODE_G2B) && !single_step;
            end else if (mode_chg) begin
                codigo_o   <= conv_code;
                step_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_module_input_gray_codec.sv
// Directed bench for module_input_gray_codec with a cycle-level reference model
// and a per-cycle compare process on the 4-bit instance.
module tb_module_input_gray_codec;

    localparam int W  = 4;
    localparam int IR = 4;
    localparam int SS = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] codigo;
    logic         mode;
    logic [W-1:0] codigo_out;
    logic         valid;
    logic         err;

    logic [7:0]   code8;
    logic         mode8 = 1'b0;
    logic [7:0]   code8_out;
    logic         valid8;
    logic         err8;

    int total = 0;
    int bad   = 0;

    module_input_gray_codec #(
        .WIDTH          (W),
        .INPUT_REFRESH  (IR),
        .STABLE_SAMPLES (SS)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .codigo_i   (codigo),
        .mode_i     (mode),
        .codigo_o   (codigo_out),
        .valid_o    (valid),
        .step_err_o (err)
    );

    module_input_gray_codec #(
        .WIDTH          (8),
        .INPUT_REFRESH  (IR),
        .STABLE_SAMPLES (1)
    ) u_dut8 (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .codigo_i   (code8),
        .mode_i     (mode8),
        .codigo_o   (code8_out),
        .valid_o    (valid8),
        .step_err_o (err8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        for (int k = 0; k < W; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic logic [W-1:0] m_conv(input logic [W-1:0] x, input logic m);
        return m ? (x ^ (x >> 1)) : m_g2b(x);
    endfunction

    logic [W-1:0] in_hist[$];
    logic [W-1:0] tick_q[$];
    logic [W-1:0] exp_q[$];
    int           edge_n;
    logic [W-1:0] m_committed;
    logic         m_mode_prev;
    logic [W-1:0] exp_code;
    logic         exp_valid;
    logic         exp_err;

    task automatic model_reset();
        in_hist.delete();
        tick_q.delete();
        exp_q.delete();
        edge_n      = 0;
        m_committed = '0;
        m_mode_prev = 1'b0;
        exp_code    = '0;
        exp_valid   = 1'b0;
        exp_err     = 1'b0;
    endtask

    task automatic model_edge();
        logic [W-1:0] s;
        logic         commit;
        logic         same;
        edge_n++;
        in_hist.push_back(codigo);
        if (in_hist.size() > 3) void'(in_hist.pop_front());
        s = (in_hist.size() == 3) ? in_hist[0] : '0;
        commit = 1'b0;
        if (edge_n % IR == 0) begin
            tick_q.push_back(s);
            if (tick_q.size() > SS) void'(tick_q.pop_front());
            same = 1'b1;
            foreach (tick_q[i]) if (tick_q[i] != s) same = 1'b0;
            commit = (tick_q.size() == SS) && same && (s != m_committed);
        end
        exp_valid = 1'b0;
        if (commit) begin
            exp_code    = m_conv(s, mode);
            exp_err     = (mode == 1'b0) && ($countones(s ^ m_committed) != 1);
            m_committed = s;
            exp_valid   = 1'b1;
        end else if (mode != m_mode_prev) begin
            exp_code  = m_conv(m_committed, mode);
            exp_err   = 1'b0;
            exp_valid = 1'b1;
        end
        if (exp_valid) exp_q.push_back(exp_code);
        m_mode_prev = mode;
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    // ---------------- scoreboard / compare ----------------
    initial begin : compare_proc
        logic [W-1:0] front;
        forever begin
            @(negedge clk);
            check("valid_o", 32'(valid), 32'(exp_valid));
            check("codigo_o", 32'(codigo_out), 32'(exp_code));
            check("step_err_o", 32'(err), 32'(exp_err));
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL exp_q: unexpected valid_o with codigo_o %0h", codigo_out);
                end else begin
                    front = exp_q.pop_front();
                    check("exp_q_front", 32'(codigo_out), 32'(front));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            step();
            if (valid) pulses++;
        end
    endtask

    task automatic wait_valid(input int max_cycles, output int n);
        n = -1;
        for (int k = 1; k <= max_cycles; k++) begin
            step();
            if (valid) begin
                n = k;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main_proc
        int           n;
        int           p1;
        int           p2;
        int           pulses;
        int           first_main;
        int           first8;
        logic [W-1:0] cap_code;
        logic         cap_err;
        logic [7:0]   cap8;

        codigo = 4'b1000;
        mode   = 1'b0;
        code8  = 8'b1100_0000;
        repeat (3) step();
        check("reset_codigo_o", 32'(codigo_out), 32'h0);
        check("reset_valid_o", 32'(valid), 32'h0);
        check("reset_step_err_o", 32'(err), 32'h0);
        check("reset_codigo8_o", 32'(code8_out), 32'h0);

        rst_n      = 1'b1;
        first_main = -1;
        first8     = -1;
        pulses     = 0;
        cap_code   = '0;
        cap_err    = 1'b0;
        cap8       = '0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (valid) begin
                pulses++;
                if (first_main < 0) begin
                    first_main = k;
                    cap_code   = codigo_out;
                    cap_err    = err;
                end
            end
            if (valid8 && first8 < 0) begin
                first8 = k;
                cap8   = code8_out;
            end
        end
        check("hold1000_latency", 32'(first_main), 32'd12);
        check("hold1000_code", 32'(cap_code), 32'b1111);
        check("hold1000_err", 32'(cap_err), 32'h0);
        check("hold1000_pulses", 32'(pulses), 32'd1);
        check("w8_latency", 32'(first8), 32'd4);
        check("w8_code", 32'(cap8), 32'b1000_0000);

        codigo = 4'b1001;
        run(4, p1);
        codigo = 4'b1000;
        run(24, p2);
        check("glitch_pulses", 32'(p1 + p2), 32'd0);
        check("glitch_code", 32'(codigo_out), 32'b1111);

        codigo = 4'b1010;
        wait_valid(30, n);
        check("c1010_seen", 32'(n > 0), 32'd1);
        check("c1010_code", 32'(codigo_out), 32'b1100);
        check("c1010_err", 32'(err), 32'h0);
        run(3, p1);

        mode = 1'b1;
        step();
        check("mode1_valid", 32'(valid), 32'd1);
        check("mode1_code", 32'(codigo_out), 32'b1111);
        step();
        check("mode1_pulse_end", 32'(valid), 32'd0);
        check("mode1_hold", 32'(codigo_out), 32'b1111);
        mode = 1'b0;
        step();
        check("mode0_valid", 32'(valid), 32'd1);
        check("mode0_code", 32'(codigo_out), 32'b1100);

        codigo = 4'b0110;
        run(10, p1);
        check("midfilter_pulses", 32'(p1), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_code", 32'(codigo_out), 32'h0);
        check("async_rst_valid", 32'(valid), 32'h0);
        check("async_rst_err", 32'(err), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        wait_valid(40, n);
        check("after_rst_latency", 32'(n), 32'd12);
        check("after_rst_code", 32'(codigo_out), 32'b0100);
        check("after_rst_err", 32'(err), 32'd1);
        run(8, p1);
        check("err_hold", 32'(err), 32'd1);
        check("err_hold_pulses", 32'(p1), 32'd0);

        #2;
        rst_n = 1'b0;
        step();
        codigo = 4'b0011;
        step();
        rst_n = 1'b1;
        wait_valid(40, n);
        check("c0011_latency", 32'(n), 32'd12);
        check("c0011_code", 32'(codigo_out), 32'b0010);
        check("c0011_err", 32'(err), 32'd1);

        step();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
